// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator's BCD conversion scheduler.
package calc_pkg;

   localparam int unsigned BIN_W   = 14;
   localparam int unsigned NDIG    = 4;
   localparam int unsigned MAX_VAL = 9999;

   // Scratch carries one spare digit so any 14-bit value (up to 16383) converts losslessly.
   localparam int unsigned SCR_DIG = NDIG + 1;
   localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_SUB  = 2'd1;
   localparam logic [1:0] SRC_ADD  = 2'd2;
   localparam logic [1:0] SRC_MUL  = 2'd3;

   localparam int unsigned GNT_SUB = 0;
   localparam int unsigned GNT_ADD = 1;
   localparam int unsigned GNT_MUL = 2;

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle between the result sources, the converter and the display driver.
interface bcd_conv_sched_if;
   import calc_pkg::*;

   logic             req_sub;
   logic             req_add;
   logic             req_mul;
   logic [BIN_W-1:0] sub_val;
   logic [BIN_W-1:0] add_val;
   logic [BIN_W-1:0] mul_val;
   logic [2:0]       grant;
   logic             busy;
   logic             done;
   logic [3:0]       digit3;
   logic [3:0]       digit2;
   logic [3:0]       digit1;
   logic [3:0]       digit0;
   logic             ovf;
   logic [1:0]       src;

   modport master (
      output req_sub, req_add, req_mul, sub_val, add_val, mul_val,
      input  grant, busy, done, digit3, digit2, digit1, digit0, ovf, src
   );

   modport slave (
      input  req_sub, req_add, req_mul, sub_val, add_val, mul_val,
      output grant, busy, done, digit3, digit2, digit1, digit0, ovf, src
   );

endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {scratch, bin} left by one.
module bcd_dd_step #(
   parameter int unsigned NDIG_S = 5,
   parameter int unsigned BIN_S  = 14
) (
   input  logic [4*NDIG_S-1:0] i_scr,
   input  logic [BIN_S-1:0]    i_bin,
   output logic [4*NDIG_S-1:0] o_scr,
   output logic [BIN_S-1:0]    o_bin
);

   logic [4*NDIG_S-1:0] w_adj;

   // Per-digit add-3 correction ahead of the shift.
   always_comb begin
      w_adj = '0;
      for (int i = 0; i < int'(NDIG_S); i++) begin
         if (i_scr[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = i_scr[4*i +: 4] + 4'd3;
         end else begin
            w_adj[4*i +: 4] = i_scr[4*i +: 4];
         end
      end
   end

   assign {o_scr, o_bin} = {w_adj[4*NDIG_S-2:0], i_bin, 1'b0};

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one bit-serial binary-to-BCD converter between the sub, add and mul results.
// Fixed priority sub > add > mul matches the display mux precedence.
module bcd_conv_sched
   import calc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   bcd_conv_sched_if.slave    io_bus
);

   state_t                 r_state;
   logic [BIN_W-1:0]       r_bin;
   logic [4*SCR_DIG-1:0]   r_scr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ovf_pend;
   logic [1:0]             r_src_pend;
   logic [2:0]             r_grant;
   logic                   r_busy;
   logic                   r_done;
   logic [4*NDIG-1:0]      r_digits;
   logic                   r_ovf;
   logic [1:0]             r_src;

   logic                   w_any_req;
   logic [BIN_W-1:0]       w_win_val;
   logic [2:0]             w_win_gnt;
   logic [1:0]             w_win_src;
   logic [4*SCR_DIG-1:0]   w_scr_nxt;
   logic [BIN_W-1:0]       w_bin_nxt;

   // Fixed-priority winner selection among pending requests.
   always_comb begin
      w_any_req = io_bus.req_sub | io_bus.req_add | io_bus.req_mul;
      w_win_val = '0;
      w_win_gnt = '0;
      w_win_src = SRC_NONE;
      if (io_bus.req_sub) begin
         w_win_val          = io_bus.sub_val;
         w_win_gnt[GNT_SUB] = 1'b1;
         w_win_src          = SRC_SUB;
      end else if (io_bus.req_add) begin
         w_win_val          = io_bus.add_val;
         w_win_gnt[GNT_ADD] = 1'b1;
         w_win_src          = SRC_ADD;
      end else if (io_bus.req_mul) begin
         w_win_val          = io_bus.mul_val;
         w_win_gnt[GNT_MUL] = 1'b1;
         w_win_src          = SRC_MUL;
      end
   end

   bcd_dd_step #(
      .NDIG_S (SCR_DIG),
      .BIN_S  (BIN_W)
   ) u_step (
      .i_scr (r_scr),
      .i_bin (r_bin),
      .o_scr (w_scr_nxt),
      .o_bin (w_bin_nxt)
   );

   // Scheduler FSM: capture, BIN_W shift iterations, then publish the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_scr      <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_src_pend <= SRC_NONE;
         r_grant    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_digits   <= '0;
         r_ovf      <= 1'b0;
         r_src      <= SRC_NONE;
      end else begin
         r_grant <= '0;
         r_done  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_bin      <= w_win_val;
                  r_scr      <= '0;
                  r_cnt      <= '0;
                  r_ovf_pend <= (w_win_val > MAX_BIN);
                  r_src_pend <= w_win_src;
                  r_grant    <= w_win_gnt;
                  r_busy     <= 1'b1;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               r_scr <= w_scr_nxt;
               r_bin <= w_bin_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(BIN_W - 1)) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               // Values above MAX_VAL saturate the display to all nines.
               r_digits <= r_ovf_pend ? {NDIG{4'd9}} : r_scr[4*NDIG-1:0];
               r_ovf    <= r_ovf_pend;
               r_src    <= r_src_pend;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.grant  = r_grant;
   assign io_bus.busy   = r_busy;
   assign io_bus.done   = r_done;
   assign io_bus.digit3 = r_digits[15:12];
   assign io_bus.digit2 = r_digits[11:8];
   assign io_bus.digit1 = r_digits[7:4];
   assign io_bus.digit0 = r_digits[3:0];
   assign io_bus.ovf    = r_ovf;
   assign io_bus.src    = r_src;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for the shared BCD converter scheduler.
module tb_bcd_conv_sched;
   import calc_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   bcd_conv_sched_if bus ();

   bcd_conv_sched u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] digits();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step from the grant cycle until done; lat counts cycles after the grant-visible sample.
   task automatic wait_done(output int lat, output bit busy_ok, output bit gnt_quiet);
      lat       = 0;
      busy_ok   = 1'b1;
      gnt_quiet = 1'b1;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.done) break;
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.grant != 3'b000) gnt_quiet = 1'b0;
      end
   endtask

   // Check a completed conversion and the following cycle's done drop.
   task automatic chk_result(input string tag, input int lat, input bit busy_ok,
                             input logic [15:0] exp_dig, input logic exp_ovf,
                             input logic [1:0] exp_src);
      chk({tag, "_lat"}, lat, 15);
      chk({tag, "_busy"}, {31'b0, busy_ok}, 1);
      chk({tag, "_digits"}, {16'b0, digits()}, {16'b0, exp_dig});
      chk({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, exp_ovf});
      chk({tag, "_src"}, {30'b0, bus.src}, {30'b0, exp_src});
      chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 0);
   endtask

   // Single request from one source, served to completion.
   task automatic serve(input string tag, input int which, input logic [BIN_W-1:0] val,
                        input logic [15:0] exp_dig, input logic exp_ovf);
      int lat;
      bit bok;
      bit gq;
      logic [2:0] g;
      g = 3'b000;
      g[which] = 1'b1;
      case (which)
         0: begin bus.req_sub = 1'b1; bus.sub_val = val; end
         1: begin bus.req_add = 1'b1; bus.add_val = val; end
         default: begin bus.req_mul = 1'b1; bus.mul_val = val; end
      endcase
      @(negedge clk);
      chk({tag, "_grant"}, {29'b0, bus.grant}, {29'b0, g});
      bus.req_sub = 1'b0;
      bus.req_add = 1'b0;
      bus.req_mul = 1'b0;
      wait_done(lat, bok, gq);
      chk_result(tag, lat, bok, exp_dig, exp_ovf, 2'(which + 1));
      @(negedge clk);
   endtask

   initial begin : stim
      int lat;
      bit bok;
      bit gq;
      total = 0;
      bad   = 0;

      // Reset with a request held: nothing may be granted.
      bus.req_sub = 1'b0;
      bus.req_add = 1'b1;
      bus.req_mul = 1'b0;
      bus.sub_val = '0;
      bus.add_val = 14'd1234;
      bus.mul_val = '0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_grant", {29'b0, bus.grant}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
      chk("rst_digits", {16'b0, digits()}, 0);
      chk("rst_ovf", {31'b0, bus.ovf}, 0);
      chk("rst_src", {30'b0, bus.src}, 0);

      // Single add request, held across reset release.
      rst = 1'b0;
      @(negedge clk);
      chk("add1234_grant", {29'b0, bus.grant}, 32'h2);
      chk("add1234_busy0", {31'b0, bus.busy}, 1);
      bus.req_add = 1'b0;
      wait_done(lat, bok, gq);
      chk_result("add1234", lat, bok, 16'h1234, 1'b0, SRC_ADD);
      @(negedge clk);
      chk("add1234_done_pulse", {31'b0, bus.done}, 0);
      chk("add1234_hold", {16'b0, digits()}, 32'h1234);

      // Three simultaneous requests: sub, then add, then mul, 16 cycles apart.
      bus.req_sub = 1'b1; bus.sub_val = 14'd42;
      bus.req_add = 1'b1; bus.add_val = 14'd7;
      bus.req_mul = 1'b1; bus.mul_val = 14'd9;
      @(negedge clk);
      chk("arb_sub_grant", {29'b0, bus.grant}, 32'h1);
      bus.req_sub = 1'b0;
      wait_done(lat, bok, gq);
      chk_result("arb_sub", lat, bok, 16'h0042, 1'b0, SRC_SUB);
      chk("arb_sub_no_regrant", {31'b0, gq}, 1);
      @(negedge clk);
      chk("arb_add_grant", {29'b0, bus.grant}, 32'h2);
      bus.req_add = 1'b0;
      wait_done(lat, bok, gq);
      chk_result("arb_add", lat, bok, 16'h0007, 1'b0, SRC_ADD);
      @(negedge clk);
      chk("arb_mul_grant", {29'b0, bus.grant}, 32'h4);
      bus.req_mul = 1'b0;
      wait_done(lat, bok, gq);
      chk_result("arb_mul", lat, bok, 16'h0009, 1'b0, SRC_MUL);
      @(negedge clk);

      // Saturation and boundaries.
      serve("sat12000", 2, 14'd12000, 16'h9999, 1'b1);
      serve("max9999", 2, 14'd9999, 16'h9999, 1'b0);
      serve("zero", 2, 14'd0, 16'h0000, 1'b0);
      serve("max10000", 1, 14'd10000, 16'h9999, 1'b1);
      serve("full16383", 0, 14'd16383, 16'h9999, 1'b1);
      serve("add9876", 1, 14'd9876, 16'h9876, 1'b0);

      // Operand changed after capture and sub raised while busy.
      bus.req_add = 1'b1;
      bus.add_val = 14'd321;
      @(negedge clk);
      chk("cap_grant", {29'b0, bus.grant}, 32'h2);
      bus.req_add = 1'b0;
      bus.add_val = 14'd555;
      bus.req_sub = 1'b1;
      bus.sub_val = 14'd88;
      wait_done(lat, bok, gq);
      chk_result("cap321", lat, bok, 16'h0321, 1'b0, SRC_ADD);
      chk("busy_no_grant", {31'b0, gq}, 1);
      @(negedge clk);
      chk("late_sub_grant", {29'b0, bus.grant}, 32'h1);
      bus.req_sub = 1'b0;
      wait_done(lat, bok, gq);
      chk_result("late_sub88", lat, bok, 16'h0088, 1'b0, SRC_SUB);
      @(negedge clk);

      // Reset in the middle of a conversion of 5678.
      bus.req_mul = 1'b1;
      bus.mul_val = 14'd5678;
      @(negedge clk);
      chk("midrst_grant", {29'b0, bus.grant}, 32'h4);
      bus.req_mul = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_busy_before", {31'b0, bus.busy}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'b0, bus.busy}, 0);
      chk("midrst_done", {31'b0, bus.done}, 0);
      chk("midrst_digits", {16'b0, digits()}, 0);
      chk("midrst_src", {30'b0, bus.src}, 0);
      chk("midrst_ovf", {31'b0, bus.ovf}, 0);
      rst = 1'b0;
      wait_done(lat, bok, gq);
      chk("midrst_no_done", lat, 40);
      chk("midrst_idle", {31'b0, bok}, 0);
      serve("post_rst5678", 1, 14'd5678, 16'h5678, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Shares one sequential binary-to-BCD converter (double-dabble, one bit per clock) between the add, sub and mul result sources of the calculator datapath.
- Arbitrates pending conversion requests with fixed priority sub > add > mul, the same precedence the display mux uses.
- Captures the winning 14-bit operand and runs the iterative conversion.
- Presents four registered BCD digits to the seven-segment driver, with a done pulse and source tag.

Parameters:
- BIN_W, 14, width of binary operands.
- NDIG, 4, number of BCD output digits.
- MAX_VAL, 9999, largest value representable on NDIG digits; larger values saturate.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_sub  in  1  level request: convert sub_val.
- req_add  in  1  level request: convert add_val.
- req_mul  in  1  level request: convert mul_val.
- sub_val  in  BIN_W  unsigned subtractor result.
- add_val  in  BIN_W  unsigned adder result.
- mul_val  in  BIN_W  unsigned multiplier result.
- grant  out  3  one-hot capture acknowledge: [0]=sub, [1]=add, [2]=mul.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: digits/src/ovf updated.
- digit3  out  4  thousands digit.
- digit2  out  4  hundreds digit.
- digit1  out  4  tens digit.
- digit0  out  4  ones digit.
- ovf  out  1  last converted value exceeded MAX_VAL.
- src  out  2  source of last result: 0 none, 1 sub, 2 add, 3 mul.

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - rst dominates everything else, including mid-conversion. On reset: state=IDLE; grant=0, busy=0, done=0, digits=0, ovf=0, src=0; scratch registers cleared. Any in-flight conversion is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - With no request asserted, remain in IDLE.
  - Otherwise, at edge E0 select the winner by fixed priority sub > add > mul.
  - Load the winner's value into the binary shift register, clear the BCD scratch, set cnt=0.
  - Set ovf_pend = (value > MAX_VAL). Record src_pend.
  - grant = winner one-hot for exactly one cycle after E0. busy=1. Go to SHIFT.
- SHIFT:
  - Each edge performs one double-dabble iteration:
    - For every scratch digit >= 5, add 3.
    - Shift {scratch, bin} left by 1.
  - cnt increments each edge. After BIN_W iterations (edges E1..E14), go to DONE.
  - The scratch holds NDIG+1 digits so that values up to 16383 convert without loss.
- DONE, at edge E15:
  - If ovf_pend is 0: digits = low NDIG scratch digits.
  - If ovf_pend is 1: digits = 9,9,9,9.
  - ovf = ovf_pend; src = src_pend.
  - done=1 for one cycle; busy=0; go to IDLE.
- Latency: capture edge E0 to done high is 15 cycles. Back-to-back requests are served from the edge after done, giving a throughput of one conversion per 16 cycles.
- Requests while busy are ignored (not queued). Requesters hold their level until they see their grant bit. A request dropped before its grant is lost, which is legal.
- Operands are sampled only at E0; later changes to *_val do not affect the running conversion.
- Simultaneous requests: the highest priority wins. Losers stay pending and are re-arbitrated in IDLE. No fairness is guaranteed; continuous req_sub starves add and mul, and this is accepted.
- Between done pulses, digits/ovf/src hold their last values.
- Boundary values: 0 converts to 0,0,0,0. MAX_VAL converts to 9,9,9,9 with ovf=0. MAX_VAL+1 gives 9,9,9,9 with ovf=1.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - src codes SRC_NONE/SUB/ADD/MUL.
  - BIN_W, NDIG and MAX_VAL constants.
  - Grant bit indices.
- Sub-module bcd_dd_step: combinational single double-dabble iteration (add-3 correction per digit, then 1-bit shift). Parameterised by digit count and instantiated once in SHIFT.

Test Plan:
- Reset: assert rst for 2 cycles with req_add=1 -> all outputs 0, no grant, busy=0.
- Single request: req_add=1, add_val=1234 -> grant=3'b010 for 1 cycle; busy for 15 cycles; done pulse with digits 1,2,3,4, src=2, ovf=0.
- Arbitration: req_sub/req_add/req_mul all 1 with values 42/7/9 -> sub served first (0,0,4,2, src=1). Then add (0,0,0,7, src=2), then mul (0,0,0,9, src=3). Done pulses are spaced 16 cycles apart.
- Saturation and boundaries: mul_val=12000 -> digits 9,9,9,9, ovf=1. Then 9999 -> 9,9,9,9, ovf=0. Then 0 -> 0,0,0,0, ovf=0.
- Busy and operand handling:
  - Change add_val mid-conversion -> the result reflects the value captured at E0.
  - Raise req_sub while busy -> no grant until after done; then sub is served.
- Reset mid-operation: rst at cycle 7 of a conversion of 5678 -> state IDLE and outputs 0 on the next cycle; no done pulse. A fresh request afterwards converts correctly.
